rob_commit: RTL and testbench

- In-order reorder buffer and commit sequencer: the producer side of the physical-register commit/free and flag-commit interface consumed by the architectural state block.
- Dispatch allocates entries in program order. Functional-unit completions mark entries done.
- The oldest done entry retires at most once per cycle and drives the register clear/set, flag update and misprediction-rollback strobes.
- A mispredicted branch flushes the whole buffer.

---
 rtl/Purple_Jade_pkg.sv | 28 ++
 rtl/rob_entry_array.sv | 101 ++++++++++
 rtl/rob_commit.sv | 123 ++++++++++++
 tb/tb_rob_commit.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/Purple_Jade_pkg.sv
// Shared widths and payload types for the reorder buffer and its consumers.
package Purple_Jade_pkg;

   localparam int unsigned ROB_DEPTH_DEFAULT = 32;
   localparam int unsigned NUM_PHYS_REG      = 128;
   localparam int unsigned NUM_FLAGS         = 4;
   localparam int unsigned NUM_FU            = 4;
   localparam int unsigned ROB_TAG_W         = $clog2(ROB_DEPTH_DEFAULT);
   localparam int unsigned PREG_W            = $clog2(NUM_PHYS_REG);

   // Payload captured at dispatch
   typedef struct packed {
      logic                 has_dest;
      logic [PREG_W-1:0]    new_preg;
      logic [PREG_W-1:0]    old_preg;
      logic [NUM_FLAGS-1:0] flag_mask;
      logic                 is_branch;
   } rob_dispatch_t;

   // One functional-unit completion report
   typedef struct packed {
      logic                 valid;
      logic [ROB_TAG_W-1:0] tag;
      logic [NUM_FLAGS-1:0] flags;
      logic                 mispredict;
   } rob_complete_t;

endpackage

// File: rtl/rob_entry_array.sv
// Reorder-buffer entry storage: valid/done state, payload, completion write ports, head read.
module rob_entry_array
   import Purple_Jade_pkg::*;
#(
   parameter int unsigned DEPTH = ROB_DEPTH_DEFAULT
) (
   input  logic                          clk_i,
   input  logic                          reset_n_i,
   input  logic                          alloc_i,
   input  logic [$clog2(DEPTH)-1:0]      alloc_tag_i,
   input  rob_dispatch_t                 alloc_entry_i,
   input  rob_complete_t [NUM_FU-1:0]    complete_i,
   input  logic                          retire_i,
   input  logic [$clog2(DEPTH)-1:0]      head_tag_i,
   input  logic                          flush_i,
   output logic                          head_ready_c,
   output rob_dispatch_t                 head_entry_c,
   output logic [NUM_FLAGS-1:0]          head_flags_c,
   output logic                          head_mispredict_c
);

   localparam int unsigned TAG_W = $clog2(DEPTH);

   logic [DEPTH-1:0]     valid_q;
   logic [DEPTH-1:0]     done_q;
   logic [DEPTH-1:0]     misp_q;
   rob_dispatch_t        entry_q [DEPTH];
   logic [NUM_FLAGS-1:0] flags_q [DEPTH];

   logic [TAG_W-1:0]     comp_tag_c [NUM_FU];
   logic [NUM_FU-1:0]    comp_hit_c;
   logic                 dup_tag_c;

   // Decode completion ports; only reports against live entries take effect
   always_comb begin
      comp_hit_c = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         comp_tag_c[k] = TAG_W'(complete_i[k].tag);
         comp_hit_c[k] = complete_i[k].valid & valid_q[comp_tag_c[k]];
      end
   end

   // Two ports reporting the same tag in one cycle is an upstream bug
   always_comb begin
      dup_tag_c = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
         for (int j = i + 1; j < NUM_FU; j++) begin
            if (complete_i[i].valid && complete_i[j].valid &&
                complete_i[i].tag == complete_i[j].tag) begin
               dup_tag_c = 1'b1;
            end
         end
      end
   end

   // Flag duplicate-tag completions in simulation
   always_ff @(posedge clk_i) begin
      if (reset_n_i) begin
         assert (!dup_tag_c);
      end
   end

   // Entry lifecycle: allocate, complete, retire; flush drops everything
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         valid_q <= '0;
         done_q  <= '0;
      end else if (flush_i) begin
         valid_q <= '0;
         done_q  <= '0;
      end else begin
         for (int k = 0; k < NUM_FU; k++) begin
            if (comp_hit_c[k]) done_q[comp_tag_c[k]] <= 1'b1;
         end
         if (retire_i) valid_q[head_tag_i] <= 1'b0;
         if (alloc_i) begin
            valid_q[alloc_tag_i] <= 1'b1;
            done_q[alloc_tag_i]  <= 1'b0;
         end
      end
   end

   // Payload storage; meaningful only while the matching valid bit is set
   always_ff @(posedge clk_i) begin
      if (!flush_i) begin
         for (int k = 0; k < NUM_FU; k++) begin
            if (comp_hit_c[k]) begin
               flags_q[comp_tag_c[k]] <= complete_i[k].flags;
               misp_q[comp_tag_c[k]]  <= complete_i[k].mispredict;
            end
         end
         if (alloc_i) entry_q[alloc_tag_i] <= alloc_entry_i;
      end
   end

   assign head_ready_c      = valid_q[head_tag_i] & done_q[head_tag_i];
   assign head_entry_c      = entry_q[head_tag_i];
   assign head_flags_c      = flags_q[head_tag_i];
   assign head_mispredict_c = misp_q[head_tag_i];

endmodule

// File: rtl/rob_commit.sv
// In-order reorder buffer: pointer/count bookkeeping, in-order retirement and flush on mispredict.
module rob_commit
   import Purple_Jade_pkg::*;
#(
   parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEFAULT
) (
   input  logic                            clk_i,
   input  logic                            reset_n_i,
   input  logic                            dispatch_valid_i,
   output logic                            dispatch_ready_o,
   input  rob_dispatch_t                   dispatch_entry_i,
   output logic [$clog2(ROB_DEPTH)-1:0]    dispatch_tag_o,
   input  rob_complete_t [NUM_FU-1:0]      complete_i,
   output logic                            rob_phys_valid_o,
   output logic [PREG_W-1:0]               rob_phys_reg_cl_o,
   output logic [PREG_W-1:0]               rob_phys_reg_set_o,
   output logic                            rob_phys_mispredict_o,
   output logic                            rob_flag_valid_o,
   output logic [2*NUM_FLAGS-1:0]          rob_flag_o,
   output logic                            flush_o,
   output logic [$clog2(ROB_DEPTH):0]      rob_count_o,
   output logic [31:0]                     commit_count_o
);

   localparam int unsigned TAG_W = $clog2(ROB_DEPTH);
   localparam int unsigned CNT_W = TAG_W + 1;

   logic [TAG_W-1:0]     head_q;
   logic [TAG_W-1:0]     tail_q;
   logic [CNT_W-1:0]     count_q;
   logic [CNT_W-1:0]     count_d;
   logic                 ready_q;

   logic                 accept_c;
   logic                 commit_c;
   logic                 flush_c;
   logic                 head_ready_c;
   rob_dispatch_t        head_entry_c;
   logic [NUM_FLAGS-1:0] head_flags_c;
   logic                 head_mispredict_c;

   assign accept_c = dispatch_valid_i & ready_q;
   assign commit_c = head_ready_c;
   assign flush_c  = commit_c & head_entry_c.is_branch & head_mispredict_c;

   rob_entry_array #(
      .DEPTH (ROB_DEPTH)
   ) u_entries (
      .clk_i             (clk_i),
      .reset_n_i         (reset_n_i),
      .alloc_i           (accept_c & ~flush_c),
      .alloc_tag_i       (tail_q),
      .alloc_entry_i     (dispatch_entry_i),
      .complete_i        (complete_i),
      .retire_i          (commit_c),
      .head_tag_i        (head_q),
      .flush_i           (flush_c),
      .head_ready_c      (head_ready_c),
      .head_entry_c      (head_entry_c),
      .head_flags_c      (head_flags_c),
      .head_mispredict_c (head_mispredict_c)
   );

   // Occupancy: dispatch and commit in the same cycle cancel out
   always_comb begin
      count_d = count_q;
      if (flush_c) begin
         count_d = '0;
      end else if (accept_c && !commit_c) begin
         count_d = count_q + CNT_W'(1);
      end else if (!accept_c && commit_c) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pointers and occupancy; ready is recomputed from the new count so a full buffer unblocks a cycle late
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ready_q <= 1'b1;
      end else begin
         count_q <= count_d;
         ready_q <= (count_d != CNT_W'(ROB_DEPTH));
         if (flush_c) begin
            head_q <= '0;
            tail_q <= '0;
         end else begin
            if (commit_c) head_q <= head_q + TAG_W'(1);
            if (accept_c) tail_q <= tail_q + TAG_W'(1);
         end
      end
   end

   // Registered single-cycle commit strobes toward the architectural state block
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rob_phys_valid_o      <= 1'b0;
         rob_phys_reg_cl_o     <= '0;
         rob_phys_reg_set_o    <= '0;
         rob_phys_mispredict_o <= 1'b0;
         rob_flag_valid_o      <= 1'b0;
         rob_flag_o            <= '0;
         flush_o               <= 1'b0;
         commit_count_o        <= '0;
      end else begin
         rob_phys_valid_o      <= commit_c & head_entry_c.has_dest;
         rob_phys_reg_cl_o     <= (commit_c & head_entry_c.has_dest) ? head_entry_c.old_preg : '0;
         rob_phys_reg_set_o    <= (commit_c & head_entry_c.has_dest) ? head_entry_c.new_preg : '0;
         rob_phys_mispredict_o <= flush_c;
         rob_flag_valid_o      <= commit_c & (head_entry_c.flag_mask != '0);
         rob_flag_o            <= commit_c ? {head_entry_c.flag_mask, head_flags_c} : '0;
         flush_o               <= flush_c;
         commit_count_o        <= commit_count_o + 32'(commit_c);
      end
   end

   assign dispatch_ready_o = ready_q;
   assign dispatch_tag_o   = tail_q;
   assign rob_count_o      = count_q;

endmodule

// File: tb/tb_rob_commit.sv
// Randomized scoreboard bench for rob_commit against a queue-based program-order model.
module tb_rob_commit;
   import Purple_Jade_pkg::*;

   localparam int unsigned DEPTH = ROB_DEPTH_DEFAULT;
   localparam int unsigned TAG_W = $clog2(DEPTH);

   logic                         clk_i;
   logic                         reset_n_i;
   logic                         dispatch_valid_i;
   logic                         dispatch_ready_o;
   rob_dispatch_t                dispatch_entry_i;
   logic [TAG_W-1:0]             dispatch_tag_o;
   rob_complete_t [NUM_FU-1:0]   complete_i;
   logic                         rob_phys_valid_o;
   logic [PREG_W-1:0]            rob_phys_reg_cl_o;
   logic [PREG_W-1:0]            rob_phys_reg_set_o;
   logic                         rob_phys_mispredict_o;
   logic                         rob_flag_valid_o;
   logic [2*NUM_FLAGS-1:0]       rob_flag_o;
   logic                         flush_o;
   logic [TAG_W:0]               rob_count_o;
   logic [31:0]                  commit_count_o;

   rob_commit #(.ROB_DEPTH(DEPTH)) dut (
      .clk_i                 (clk_i),
      .reset_n_i             (reset_n_i),
      .dispatch_valid_i      (dispatch_valid_i),
      .dispatch_ready_o      (dispatch_ready_o),
      .dispatch_entry_i      (dispatch_entry_i),
      .dispatch_tag_o        (dispatch_tag_o),
      .complete_i            (complete_i),
      .rob_phys_valid_o      (rob_phys_valid_o),
      .rob_phys_reg_cl_o     (rob_phys_reg_cl_o),
      .rob_phys_reg_set_o    (rob_phys_reg_set_o),
      .rob_phys_mispredict_o (rob_phys_mispredict_o),
      .rob_flag_valid_o      (rob_flag_valid_o),
      .rob_flag_o            (rob_flag_o),
      .flush_o               (flush_o),
      .rob_count_o           (rob_count_o),
      .commit_count_o        (commit_count_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Program-order model entry and expected commit record
   typedef struct {
      logic [TAG_W-1:0]     tag;
      rob_dispatch_t        d;
      bit                   done;
      logic [NUM_FLAGS-1:0] flags;
      bit                   misp;
   } m_ent_t;

   typedef struct {
      int unsigned            edge_no;
      bit                     pv;
      logic [PREG_W-1:0]      cl;
      logic [PREG_W-1:0]      st;
      bit                     fv;
      logic [2*NUM_FLAGS-1:0] fl;
      bit                     misp;
      int unsigned            cc;
   } exp_t;

   m_ent_t           m_q[$];
   exp_t             exp_q[$];
   logic [TAG_W-1:0] m_tail;
   int unsigned      m_commits;
   int unsigned      edge_no;
   int unsigned      checks;
   int unsigned      failures;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
      end
   endtask

   function automatic rob_dispatch_t mk(input bit hd, input int unsigned np, input int unsigned op,
                                        input logic [NUM_FLAGS-1:0] mask, input bit br);
      rob_dispatch_t d;
      d.has_dest  = hd;
      d.new_preg  = PREG_W'(np);
      d.old_preg  = PREG_W'(op);
      d.flag_mask = mask;
      d.is_branch = br;
      return d;
   endfunction

   function automatic rob_complete_t mkc(input int unsigned tag, input logic [NUM_FLAGS-1:0] fl, input bit mp);
      rob_complete_t c;
      c.valid      = 1'b1;
      c.tag        = ROB_TAG_W'(tag);
      c.flags      = fl;
      c.mispredict = mp;
      return c;
   endfunction

   function automatic rob_dispatch_t rand_entry(input bit allow_branch);
      rob_dispatch_t d;
      d.has_dest  = 1'($urandom_range(0, 1));
      d.new_preg  = PREG_W'($urandom);
      d.old_preg  = PREG_W'($urandom);
      d.flag_mask = ($urandom_range(0, 2) == 0) ? '0 : NUM_FLAGS'($urandom);
      d.is_branch = allow_branch && ($urandom_range(0, 5) == 0);
      return d;
   endfunction

   // Reference behaviour for one clock edge, using the inputs sampled at that edge
   task automatic model_edge();
      bit     commit;
      bit     ready;
      m_ent_t h;
      m_ent_t ne;
      exp_t   e;
      edge_no++;
      if (!reset_n_i) return;
      ready  = (m_q.size() != DEPTH);
      commit = (m_q.size() > 0) && m_q[0].done;
      if (commit) begin
         h = m_q[0];
         m_commits++;
         e.edge_no = edge_no;
         e.pv      = h.d.has_dest;
         e.cl      = h.d.old_preg;
         e.st      = h.d.new_preg;
         e.fv      = (h.d.flag_mask != '0);
         e.fl      = {h.d.flag_mask, h.flags};
         e.misp    = h.d.is_branch && h.misp;
         e.cc      = m_commits;
         exp_q.push_back(e);
         if (e.misp) begin
            m_q.delete();
            m_tail = '0;
            return;
         end
      end
      for (int k = 0; k < NUM_FU; k++) begin
         if (complete_i[k].valid) begin
            foreach (m_q[i]) begin
               if (m_q[i].tag == TAG_W'(complete_i[k].tag)) begin
                  m_q[i].done  = 1'b1;
                  m_q[i].flags = complete_i[k].flags;
                  m_q[i].misp  = complete_i[k].mispredict;
               end
            end
         end
      end
      if (commit) void'(m_q.pop_front());
      if (dispatch_valid_i && ready) begin
         ne.tag   = m_tail;
         ne.d     = dispatch_entry_i;
         ne.done  = 1'b0;
         ne.flags = '0;
         ne.misp  = 1'b0;
         m_q.push_back(ne);
         m_tail = TAG_W'(m_tail + 1'b1);
      end
   endtask

   // Advance one cycle; state outputs are compared on the falling edge
   task automatic step();
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
      chk("rob_count", 64'(rob_count_o), 64'(m_q.size()));
      chk("dispatch_ready", 64'(dispatch_ready_o), 64'(m_q.size() != DEPTH));
      chk("dispatch_tag", 64'(dispatch_tag_o), 64'(m_tail));
   endtask

   task automatic idle();
      dispatch_valid_i = 1'b0;
      dispatch_entry_i = '0;
      complete_i       = '0;
   endtask

   task automatic disp(input rob_dispatch_t d);
      dispatch_valid_i = 1'b1;
      dispatch_entry_i = d;
      step();
      dispatch_valid_i = 1'b0;
   endtask

   task automatic comp1(input int unsigned tag, input logic [NUM_FLAGS-1:0] fl, input bit mp);
      complete_i    = '0;
      complete_i[0] = mkc(tag, fl, mp);
      step();
      complete_i    = '0;
   endtask

   task automatic model_clear();
      m_q.delete();
      exp_q.delete();
      m_tail    = '0;
      m_commits = 0;
   endtask

   // Called on a falling edge; leaves reset released on a falling edge
   task automatic do_reset();
      idle();
      #1 reset_n_i = 1'b0;
      #1 model_clear();
      @(negedge clk_i);
      step();
      reset_n_i = 1'b1;
   endtask

   task automatic drive_random(input int unsigned dpct, input int unsigned cpct);
      logic [DEPTH-1:0] used;
      logic [TAG_W-1:0] t;
      int               n;
      int               i;
      bit               inq;
      used             = '0;
      dispatch_valid_i = ($urandom_range(0, 99) < dpct);
      dispatch_entry_i = rand_entry(1'b1);
      complete_i       = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         if ($urandom_range(0, 99) >= cpct) continue;
         if (m_q.size() > 0 && $urandom_range(0, 9) != 0) begin
            n = (m_q.size() < 8) ? m_q.size() : 8;
            i = int'($urandom_range(0, 32'(n - 1)));
            if (m_q[i].done || used[m_q[i].tag]) continue;
            t = m_q[i].tag;
         end else begin
            t   = TAG_W'($urandom_range(0, DEPTH - 1));
            inq = 1'b0;
            foreach (m_q[j]) if (m_q[j].tag == t) inq = 1'b1;
            if (inq || used[t]) continue;
         end
         used[t]       = 1'b1;
         complete_i[k] = mkc(32'(t), NUM_FLAGS'($urandom), ($urandom_range(0, 7) == 0));
      end
   endtask

   // Scoreboard monitor: every visible retirement pops and checks one expected commit
   initial begin : monitor
      exp_t        e;
      logic [31:0] prev_cc;
      prev_cc = '0;
      forever begin
         @(negedge clk_i);
         if (!reset_n_i) begin
            prev_cc = '0;
         end else if (commit_count_o != prev_cc) begin
            prev_cc = commit_count_o;
            if (exp_q.size() == 0) begin
               chk("unexpected_commit", 64'(commit_count_o), 64'(m_commits));
            end else begin
               e = exp_q.pop_front();
               chk("commit_edge", 64'(edge_no), 64'(e.edge_no));
               chk("commit_count", 64'(commit_count_o), 64'(e.cc));
               chk("phys_valid", 64'(rob_phys_valid_o), 64'(e.pv));
               if (e.pv) begin
                  chk("phys_cl", 64'(rob_phys_reg_cl_o), 64'(e.cl));
                  chk("phys_set", 64'(rob_phys_reg_set_o), 64'(e.st));
               end
               chk("flag_valid", 64'(rob_flag_valid_o), 64'(e.fv));
               if (e.fv) chk("flag_value", 64'(rob_flag_o), 64'(e.fl));
               chk("mispredict", 64'(rob_phys_mispredict_o), 64'(e.misp));
               chk("flush", 64'(flush_o), 64'(e.misp));
            end
         end else begin
            chk("stray_strobe",
                64'({rob_phys_valid_o, rob_flag_valid_o, rob_phys_mispredict_o, flush_o}), 64'(0));
         end
      end
   end

   initial begin : driver
      checks    = 0;
      failures  = 0;
      edge_no   = 0;
      reset_n_i = 1'b0;
      idle();
      model_clear();
      repeat (2) @(negedge clk_i);

      // Reset state
      chk("rst_phys_valid", 64'(rob_phys_valid_o), 64'(0));
      chk("rst_flag_valid", 64'(rob_flag_valid_o), 64'(0));
      chk("rst_flag", 64'(rob_flag_o), 64'(0));
      chk("rst_mispredict", 64'(rob_phys_mispredict_o), 64'(0));
      chk("rst_flush", 64'(flush_o), 64'(0));
      chk("rst_ready", 64'(dispatch_ready_o), 64'(1));
      chk("rst_count", 64'(rob_count_o), 64'(0));
      chk("rst_tag", 64'(dispatch_tag_o), 64'(0));
      chk("rst_commit_count", 64'(commit_count_o), 64'(0));
      reset_n_i = 1'b1;

      // Single dispatch, completion latency to commit strobe
      do_reset();
      disp(mk(1'b1, 40, 5, 4'b0000, 1'b0));
      comp1(0, 4'b0000, 1'b0);
      chk("single_not_early", 64'(rob_phys_valid_o), 64'(0));
      step();
      chk("single_phys_valid", 64'(rob_phys_valid_o), 64'(1));
      chk("single_cl", 64'(rob_phys_reg_cl_o), 64'(5));
      chk("single_set", 64'(rob_phys_reg_set_o), 64'(40));
      chk("single_flag_valid", 64'(rob_flag_valid_o), 64'(0));
      chk("single_commit_count", 64'(commit_count_o), 64'(1));
      chk("single_count", 64'(rob_count_o), 64'(0));
      step();
      chk("single_strobe_width", 64'(rob_phys_valid_o), 64'(0));

      // Out-of-order completion, in-order commit
      do_reset();
      for (int i = 0; i < 3; i++) disp(mk(1'b1, 10 + i, i, 4'b0000, 1'b0));
      comp1(2, 4'b0000, 1'b0);
      comp1(1, 4'b0000, 1'b0);
      comp1(0, 4'b0000, 1'b0);
      step();
      chk("ooo_first", 64'(rob_phys_reg_set_o), 64'(10));
      step();
      chk("ooo_second", 64'(rob_phys_reg_set_o), 64'(11));
      step();
      chk("ooo_third", 64'(rob_phys_reg_set_o), 64'(12));
      chk("ooo_commit_count", 64'(commit_count_o), 64'(3));

      // Flag-only entry
      do_reset();
      disp(mk(1'b0, 0, 0, 4'b0011, 1'b0));
      comp1(0, 4'b1110, 1'b0);
      step();
      chk("flagonly_valid", 64'(rob_flag_valid_o), 64'(1));
      chk("flagonly_value", 64'(rob_flag_o), 64'(8'b0011_1110));
      chk("flagonly_phys", 64'(rob_phys_valid_o), 64'(0));

      // Fill to full, commit while dispatch is held
      do_reset();
      dispatch_valid_i = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         dispatch_entry_i = rand_entry(1'b0);
         step();
      end
      chk("full_ready", 64'(dispatch_ready_o), 64'(0));
      chk("full_count", 64'(rob_count_o), 64'(DEPTH));
      chk("full_tag_wrap", 64'(dispatch_tag_o), 64'(0));
      complete_i[0] = mkc(0, 4'b0101, 1'b0);
      step();
      complete_i = '0;
      chk("full_ready_commit_cycle", 64'(dispatch_ready_o), 64'(0));
      step();
      chk("full_ready_after", 64'(dispatch_ready_o), 64'(1));
      chk("full_count_after", 64'(rob_count_o), 64'(DEPTH - 1));
      step();
      chk("full_refill", 64'(rob_count_o), 64'(DEPTH));
      idle();

      // Mispredicted branch at tag 3 with younger tags 4-6
      do_reset();
      for (int i = 0; i < 7; i++) disp(mk(1'b1, 50 + i, 10 + i, 4'b0000, i == 3));
      complete_i[0] = mkc(4, 4'b0000, 1'b0);
      complete_i[1] = mkc(5, 4'b0000, 1'b0);
      complete_i[2] = mkc(6, 4'b0000, 1'b0);
      complete_i[3] = mkc(3, 4'b1001, 1'b1);
      step();
      complete_i    = '0;
      complete_i[0] = mkc(0, 4'b0000, 1'b0);
      complete_i[1] = mkc(1, 4'b0000, 1'b1);
      complete_i[2] = mkc(2, 4'b0000, 1'b0);
      step();
      idle();
      repeat (3) step();
      chk("misp_no_early_flush", 64'(flush_o), 64'(0));
      step();
      chk("misp_flush", 64'(flush_o), 64'(1));
      chk("misp_strobe", 64'(rob_phys_mispredict_o), 64'(1));
      chk("misp_set", 64'(rob_phys_reg_set_o), 64'(53));
      step();
      chk("misp_flush_width", 64'(flush_o), 64'(0));
      chk("misp_count", 64'(rob_count_o), 64'(0));
      chk("misp_commit_count", 64'(commit_count_o), 64'(4));
      chk("misp_next_tag", 64'(dispatch_tag_o), 64'(0));
      disp(mk(1'b1, 7, 8, 4'b0000, 1'b0));
      repeat (4) step();
      chk("misp_no_young_commit", 64'(commit_count_o), 64'(4));

      // Asynchronous reset with entries pending and a strobe on the outputs
      do_reset();
      for (int i = 0; i < 6; i++) disp(mk(1'b1, 20 + i, i, 4'b0001, 1'b0));
      complete_i[0] = mkc(0, 4'b0001, 1'b0);
      complete_i[1] = mkc(2, 4'b0001, 1'b0);
      complete_i[2] = mkc(3, 4'b0001, 1'b0);
      complete_i[3] = mkc(4, 4'b0001, 1'b0);
      step();
      idle();
      step();
      chk("arst_pre_strobe", 64'(rob_phys_valid_o), 64'(1));
      chk("arst_pre_count", 64'(rob_count_o), 64'(5));
      #2 reset_n_i = 1'b0;
      #1;
      chk("arst_phys_valid", 64'(rob_phys_valid_o), 64'(0));
      chk("arst_cl_set", 64'({rob_phys_reg_cl_o, rob_phys_reg_set_o}), 64'(0));
      chk("arst_flag", 64'({rob_flag_valid_o, rob_flag_o}), 64'(0));
      chk("arst_flush", 64'({rob_phys_mispredict_o, flush_o}), 64'(0));
      chk("arst_count", 64'(rob_count_o), 64'(0));
      chk("arst_commit_count", 64'(commit_count_o), 64'(0));
      chk("arst_ready", 64'(dispatch_ready_o), 64'(1));
      model_clear();
      @(negedge clk_i);
      reset_n_i = 1'b1;
      comp1(1, 4'b0000, 1'b0);
      repeat (4) step();
      chk("arst_no_commit", 64'(commit_count_o), 64'(0));

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 900; c++) begin drive_random(90, 25); step(); end
      for (int c = 0; c < 900; c++) begin drive_random(70, 60); step(); end
      for (int c = 0; c < 900; c++) begin drive_random(35, 85); step(); end

      // Drain whatever is left
      for (int c = 0; c < 3000 && m_q.size() > 0; c++) begin drive_random(0, 90); step(); end
      idle();
      repeat (3) step();
      chk("drain_count", 64'(rob_count_o), 64'(0));
      chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
